// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the 3-card monotonic-sequence protocol.
//   mode_e        value-generation mode captured with start
//   state_e       burst FSM states of seq_driver
//   LFSR_TAPS     feedback taps of the 8-bit LFSR (q[7]^q[5]^q[4]^q[3])
//   is_monotonic  verdict of one 3-value window; the checker and the driver
//                 both call it so their notions of "monotonic" cannot drift.
package seq_pkg;

    typedef enum logic [1:0] {
        MODE_ASC    = 2'd0,
        MODE_DESC   = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_ZIGZAG = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
    localparam logic [7:0] ERR_MAX   = 8'hFF;

    function automatic logic lfsr_feedback(input logic [7:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

    // Strict, unsigned: equal neighbours and a 15->0 wrap both break the run.
    function automatic logic is_monotonic(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic [3:0] c);
        return ((a < b) && (b < c)) || ((a > b) && (b > c));
    endfunction

endpackage

// File: rtl/seq_src.sv
// seq_src: 4-bit value generator for one burst.
//   clk, rst  clock and synchronous active-high reset
//   load      capture mode/base and present v(0) from the next cycle
//   step      advance to v(k+1)
//   mode      ASC / DESC / LFSR / ZIGZAG
//   base      first value (ASC/DESC/ZIGZAG) or LFSR seed nibble
//   value     current value v(k)
module seq_src
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  mode_e      mode,
    input  logic [3:0] base,
    output logic [3:0] value
);

    mode_e      mode_q;
    logic [3:0] base_q;
    logic [3:0] val_q;
    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_ASC;
            base_q <= '0;
            val_q  <= '0;
            lfsr_q <= '0;
        end else if (load) begin
            mode_q <= mode;
            base_q <= base;
            val_q  <= base;
            lfsr_q <= {base, ~base};
        end else if (step) begin
            // The LFSR free-runs while stepping; it is only visible in LFSR mode.
            lfsr_q <= {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
            case (mode_q)
                MODE_ASC:    val_q <= val_q + 4'd1;
                MODE_DESC:   val_q <= val_q - 4'd1;
                // base+1 can never equal base mod 16, so this alternates cleanly.
                MODE_ZIGZAG: val_q <= (val_q == base_q) ? (base_q + 4'd1) : base_q;
                default:     val_q <= val_q;
            endcase
        end
    end

    assign value = (mode_q == MODE_LFSR) ? lfsr_q[3:0] : val_q;

endmodule

// File: rtl/seq_driver.sv
// seq_driver: burst transmitter and verdict checker for the 3-card
// monotonic-sequence protocol.
//   LEN         values per burst (3..255); LEN-2 windows per burst
//   clk, rst    clock and synchronous active-high reset
//   start       burst request, honoured only in IDLE
//   mode, base  generation mode and first value / seed, captured with start
//   seq_valid   stream valid to the checker's in_valid
//   seq_data    stream value to the checker's in_data
//   resp_valid  checker's out_valid
//   resp_data   checker's out_data (window verdict)
//   busy        high in every state except IDLE
//   done        one-cycle pulse in REPORT
//   pass        valid with done; high iff err_cnt is zero
//   err_cnt     mismatches in the last burst, saturating, held until next start
//   state_dbg   current FSM state (state_e encoding)
//
// Both streams are valid-only with no backpressure: the checker consumes a
// value every cycle seq_valid is high, and its verdict arrives exactly one
// cycle after the value that completes a window, whether or not we are ready.
module seq_driver
    import seq_pkg::*;
#(
    parameter int LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [3:0] base,
    output logic       seq_valid,
    output logic [3:0] seq_data,
    input  logic       resp_valid,
    input  logic       resp_data,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [1:0] state_dbg
);

    localparam logic [7:0] K_LAST = 8'(LEN - 1);

    state_e     state_q;
    state_e     state_d;
    logic [7:0] k_q;
    logic [3:0] h1_q;        // v(k-1)
    logic [3:0] h2_q;        // v(k-2)
    logic       exp_vld_q;   // a verdict is due this cycle
    logic       exp_q;       // the verdict that is due
    logic [7:0] err_cnt_q;
    logic [3:0] src_value;

    logic load;
    logic step;
    logic in_burst;
    logic window_full;
    logic exp_now;
    logic err_now;

    assign load        = (state_q == ST_IDLE) && start;
    assign step        = (state_q == ST_SEND);
    assign in_burst    = (state_q != ST_IDLE);
    assign window_full = (k_q >= 8'd2);
    assign exp_now     = is_monotonic(h2_q, h1_q, src_value);

    // One error at most per cycle: either the due verdict is missing/wrong,
    // or a verdict shows up when none is due.
    assign err_now = exp_vld_q ? (!resp_valid || (resp_data != exp_q)) : resp_valid;

    seq_src u_src (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .mode  (mode_e'(mode)),
        .base  (base),
        .value (src_value)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SEND;
            ST_SEND:   if (k_q == K_LAST) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        seq_valid = 1'b0;
        seq_data  = '0;
        busy      = 1'b1;
        done      = 1'b0;
        pass      = 1'b0;
        case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_SEND: begin
                seq_valid = 1'b1;
                seq_data  = src_value;
            end
            ST_REPORT: begin
                done = 1'b1;
                pass = (err_cnt_q == 8'd0);
            end
            default: ;
        endcase
    end

    // Index, history, expectation pipeline and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q       <= '0;
            h1_q      <= '0;
            h2_q      <= '0;
            exp_vld_q <= 1'b0;
            exp_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (load) begin
                k_q <= '0;
            end else if (step) begin
                k_q <= k_q + 8'd1;
            end

            if (step) begin
                h2_q <= h1_q;
                h1_q <= src_value;
            end

            // The checker answers one cycle after the value that closes a
            // window, so the expectation is delayed by one register.
            exp_vld_q <= step && window_full;
            exp_q     <= step && window_full && exp_now;

            if (load) begin
                err_cnt_q <= '0;
            end else if (in_burst && err_now && (err_cnt_q != ERR_MAX)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign err_cnt   = err_cnt_q;
    assign state_dbg = state_q;

endmodule
